// File: rtl/pool_lane_engine.sv
// Parallel max/average pooling over LANES channels with a lane-serialising writeback port.
// Average mode scales the window sum by a host-supplied reciprocal instead of dividing.
module pool_lane_engine #(
    parameter int LANES = 8,
    parameter int DW    = 16,
    parameter int KS_W  = 8,
    parameter int ACC_W = 24,
    parameter int FRAC  = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       mode,
    input  logic [KS_W-1:0]            kernel_size,
    input  logic [DW-1:0]              recip,
    input  logic                       relu_en,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*DW-1:0]        in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DW-1:0]              out_data,
    output logic [$clog2(LANES)-1:0]   out_lane,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done,
    output logic                       err_cfg
);
    localparam int LW = $clog2(LANES);
    localparam int PW = ACC_W + DW + 1;
    localparam logic signed [PW-1:0] HALF   = PW'(1) << (FRAC - 1);
    localparam logic signed [PW-1:0] SAT_HI = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_LO = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, SCALE, DRAIN} state_t;

    state_t              state_reg, state_next;
    logic                mode_reg, relu_reg;
    logic [KS_W-1:0]     ks_reg, elem_cnt_reg;
    logic [DW-1:0]       recip_reg;
    logic [LW-1:0]       lane_idx_reg;
    logic                done_reg, err_reg;
    logic                hs, first_beat, last_beat, load_res;
    logic [LANES*DW-1:0] res_flat;

    assign hs         = in_valid && in_ready;
    assign first_beat = (elem_cnt_reg == '0);
    assign last_beat  = (elem_cnt_reg == ks_reg - 1'b1);
    // Max results are latched straight from the final compare; average waits for SCALE.
    assign load_res   = (state_reg == SCALE) || (hs && last_beat && !mode_reg);

    assign out_last = (state_reg == DRAIN) && (lane_idx_reg == LW'(LANES - 1));
    assign out_lane = lane_idx_reg;
    assign out_data = res_flat[lane_idx_reg*DW +: DW];
    assign done     = done_reg;
    assign err_cfg  = err_reg;

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (start && kernel_size != '0)
                    state_next = ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (hs && last_beat)
                    state_next = mode_reg ? SCALE : DRAIN;
            end
            SCALE: state_next = DRAIN;
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && out_last)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            mode_reg     <= 1'b0;
            relu_reg     <= 1'b0;
            ks_reg       <= '0;
            recip_reg    <= '0;
            elem_cnt_reg <= '0;
            lane_idx_reg <= '0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            if (state_reg == IDLE && start) begin
                if (kernel_size == '0) begin
                    err_reg <= 1'b1;
                end else begin
                    mode_reg     <= mode;
                    relu_reg     <= relu_en;
                    ks_reg       <= kernel_size;
                    recip_reg    <= recip;
                    elem_cnt_reg <= '0;
                    lane_idx_reg <= '0;
                end
            end
            if (hs)
                elem_cnt_reg <= elem_cnt_reg + 1'b1;
            if (out_valid && out_ready) begin
                lane_idx_reg <= lane_idx_reg + 1'b1;
                if (out_last)
                    done_reg <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [ACC_W-1:0] acc_reg, acc_next, elem_ext;
        logic signed [PW-1:0]    prod, rnd;
        logic signed [DW-1:0]    sat_val, pick;
        logic [DW-1:0]           res_next, res_reg;

        assign elem_ext = {{(ACC_W-DW){in_data[gi*DW+DW-1]}}, in_data[gi*DW +: DW]};

        always_comb begin
            acc_next = acc_reg;
            if (first_beat)
                acc_next = elem_ext;
            else if (mode_reg)
                acc_next = acc_reg + elem_ext;
            else if (elem_ext > acc_reg)
                acc_next = elem_ext;
        end

        // recip is unsigned, so it is zero-extended before the signed multiply.
        assign prod = {{(PW-ACC_W){acc_reg[ACC_W-1]}}, acc_reg} * {{(PW-DW){1'b0}}, recip_reg};
        assign rnd  = (prod + HALF) >>> FRAC;

        always_comb begin
            sat_val = rnd[DW-1:0];
            if (rnd > SAT_HI)
                sat_val = {1'b0, {(DW-1){1'b1}}};
            else if (rnd < SAT_LO)
                sat_val = {1'b1, {(DW-1){1'b0}}};
        end

        assign pick     = (state_reg == SCALE) ? sat_val : acc_next[DW-1:0];
        assign res_next = (relu_reg && pick[DW-1]) ? '0 : pick;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc_reg <= '0;
                res_reg <= '0;
            end else begin
                if (hs)
                    acc_reg <= acc_next;
                if (load_res)
                    res_reg <= res_next;
            end
        end

        assign res_flat[gi*DW +: DW] = res_reg;
    end
endmodule
